// File: rtl/i2c24_pkg.sv
// Shared types for the 24-bit I2C configuration-write responder.
package i2c24_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR    = 4'd1,
        ACK_A   = 4'd2,
        BYTE_HI = 4'd3,
        ACK_H   = 4'd4,
        BYTE_LO = 4'd5,
        ACK_L   = 4'd6,
        EXTRA   = 4'd7,
        IGNORE  = 4'd8
    } i2c_rx_state_t;

    localparam logic       RW_WRITE = 1'b0;
    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line, with level and edge pulses.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain and previous-value flop; both idle high like the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_r[SYNC_STAGES-1];
    assign rise = lvl & ~prev_r;
    assign fall = ~lvl & prev_r;

endmodule

// File: rtl/i2c24_slave_rcv.sv
// I2C write-only responder: receives address/W plus two data bytes, ACKs them,
// and presents the 16-bit word with a one-cycle valid strobe.
module i2c24_slave_rcv
    import i2c24_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    output logic [15:0] rx_data,
    output logic        rx_vld,
    output logic        rx_err,
    output logic        busy
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic scl_pre_s, start_s, stop_s;

    i2c_rx_state_t state_r, state_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic          byte_done_r, byte_done_n;
    logic [7:0]    shift_r, shift_n;
    logic [7:0]    hi_byte_r, hi_byte_n;
    logic          addr_hit_r, addr_hit_n;
    logic [15:0]   rx_data_r, rx_data_n;
    logic          rx_vld_r, rx_vld_n;
    logic          rx_err_r, rx_err_n;
    logic          busy_r, busy_n;
    logic          sda_drv_r, sda_drv_n;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCL),
        .lvl  (scl_lvl_s),
        .rise (scl_rise_s),
        .fall (scl_fall_s)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SDA),
        .lvl  (sda_lvl_s),
        .rise (sda_rise_s),
        .fall (sda_fall_s)
    );

    // SCL value before any edge this clk, so a coincident SCL edge cannot fake START/STOP.
    assign scl_pre_s = scl_rise_s ? 1'b0 : (scl_fall_s ? 1'b1 : scl_lvl_s);
    assign start_s   = sda_fall_s & scl_pre_s;
    assign stop_s    = sda_rise_s & scl_pre_s;

    // Frame decoder: bus conditions first, then per-state shifting and ACK handling.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        byte_done_n = byte_done_r;
        shift_n     = shift_r;
        hi_byte_n   = hi_byte_r;
        addr_hit_n  = addr_hit_r;
        rx_data_n   = rx_data_r;
        rx_vld_n    = 1'b0;
        rx_err_n    = 1'b0;
        sda_drv_n   = sda_drv_r;
        if (start_s) begin
            state_n     = ADDR;
            bit_cnt_n   = 3'd0;
            byte_done_n = 1'b0;
            addr_hit_n  = 1'b0;
            sda_drv_n   = 1'b0;
        end else if (stop_s) begin
            state_n     = IDLE;
            bit_cnt_n   = 3'd0;
            byte_done_n = 1'b0;
            addr_hit_n  = 1'b0;
            sda_drv_n   = 1'b0;
            rx_err_n    = (state_r == BYTE_HI) || (state_r == BYTE_LO);
        end else begin
            case (state_r)
                ADDR, BYTE_HI, BYTE_LO, EXTRA: begin
                    if (scl_rise_s) begin
                        shift_n     = {shift_r[6:0], sda_lvl_s};
                        byte_done_n = (bit_cnt_r == LAST_BIT);
                        bit_cnt_n   = bit_cnt_r + 3'd1;
                        // Address match is known once the 7th address bit is in.
                        if ((state_r == ADDR) && (bit_cnt_r == 3'd6)) begin
                            addr_hit_n = ({shift_r[5:0], sda_lvl_s} == SLV_ADDR);
                        end else begin
                            addr_hit_n = addr_hit_r;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_n = 1'b0;
                        bit_cnt_n   = 3'd0;
                        case (state_r)
                            ADDR: begin
                                if (shift_r[7:1] == SLV_ADDR) begin
                                    if (shift_r[0] == RW_WRITE) begin
                                        state_n   = ACK_A;
                                        sda_drv_n = 1'b1;
                                    end else begin
                                        state_n  = IGNORE;
                                        rx_err_n = 1'b1;
                                    end
                                end else begin
                                    state_n = IGNORE;
                                end
                            end
                            BYTE_HI: begin
                                hi_byte_n = shift_r;
                                state_n   = ACK_H;
                                sda_drv_n = 1'b1;
                            end
                            BYTE_LO: begin
                                rx_data_n = {hi_byte_r, shift_r};
                                rx_vld_n  = 1'b1;
                                state_n   = ACK_L;
                                sda_drv_n = 1'b1;
                            end
                            default: begin
                                // A byte beyond the 16-bit word is refused.
                                rx_err_n = 1'b1;
                                state_n  = IGNORE;
                            end
                        endcase
                    end else begin
                        state_n = state_r;
                    end
                end
                ACK_A, ACK_H, ACK_L: begin
                    if (scl_fall_s) begin
                        sda_drv_n   = 1'b0;
                        bit_cnt_n   = 3'd0;
                        byte_done_n = 1'b0;
                        case (state_r)
                            ACK_A:   state_n = BYTE_HI;
                            ACK_H:   state_n = BYTE_LO;
                            default: state_n = EXTRA;
                        endcase
                    end else begin
                        sda_drv_n = sda_drv_r;
                    end
                end
                IDLE, IGNORE: begin
                    state_n = state_r;
                end
                default: begin
                    state_n   = IDLE;
                    sda_drv_n = 1'b0;
                end
            endcase
        end
    end

    // busy follows the state being entered so it is registered with it.
    always_comb begin
        busy_n = 1'b0;
        case (state_n)
            ADDR:                                      busy_n = addr_hit_n;
            ACK_A, BYTE_HI, ACK_H, BYTE_LO, ACK_L, EXTRA: busy_n = 1'b1;
            default:                                   busy_n = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            shift_r     <= 8'h00;
            hi_byte_r   <= 8'h00;
            addr_hit_r  <= 1'b0;
            rx_data_r   <= 16'h0000;
            rx_vld_r    <= 1'b0;
            rx_err_r    <= 1'b0;
            busy_r      <= 1'b0;
            sda_drv_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            byte_done_r <= byte_done_n;
            shift_r     <= shift_n;
            hi_byte_r   <= hi_byte_n;
            addr_hit_r  <= addr_hit_n;
            rx_data_r   <= rx_data_n;
            rx_vld_r    <= rx_vld_n;
            rx_err_r    <= rx_err_n;
            busy_r      <= busy_n;
            sda_drv_r   <= sda_drv_n;
        end
    end

    assign SDA     = sda_drv_r ? 1'b0 : 1'bz;
    assign rx_data = rx_data_r;
    assign rx_vld  = rx_vld_r;
    assign rx_err  = rx_err_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_i2c24_slave_rcv.sv
// Directed bench: an I2C master model drives frames into i2c24_slave_rcv.
module tb_i2c24_slave_rcv;

    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    wire         sda_w;
    logic [15:0] rx_data;
    logic        rx_vld, rx_err, busy;

    int tests_run = 0;
    int tests_failed = 0;
    int vld_cnt = 0, err_cnt = 0, both_cnt = 0, drv_cnt = 0;
    int v0, e0, d0;
    logic ack;
    logic dummy;
    logic [7:0] hb;

    assign sda_w = m_sda ? 1'bz : 1'b0;
    pullup (sda_w);

    i2c24_slave_rcv #(.SLV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .SCL     (scl),
        .SDA     (sda_w),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_err  (rx_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Pulse and slave-drive counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_vld === 1'b1) vld_cnt++;
        if (rx_err === 1'b1) err_cnt++;
        if (rx_vld === 1'b1 && rx_err === 1'b1) both_cnt++;
        if (sda_w === 1'b0 && m_sda === 1'b1) drv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_tx(input logic b, output logic seen);
        #Q m_sda = b;
        #Q scl = 1'b1;
        #Q seen = sda_w;
        #Q scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_tx(b[i], s);
        bit_tx(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic start_c();
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic stop_c();
        #Q m_sda = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
        repeat (6) @(negedge clk);
    endtask

    task automatic snap();
        v0 = vld_cnt;
        e0 = err_cnt;
        d0 = drv_cnt;
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h0000);
        check("rst_rx_vld", 32'(rx_vld), 32'h0);
        check("rst_rx_err", 32'(rx_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sda", 32'(sda_w), 32'h1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0x1A/W, 0xA5, 0x5A
        snap();
        start_c();
        send_byte(8'h34, ack); check("t1_ack_addr", 32'(ack), 32'h1);
        send_byte(8'hA5, ack); check("t1_ack_hi", 32'(ack), 32'h1);
        check("t1_busy_mid", 32'(busy), 32'h1);
        send_byte(8'h5A, ack); check("t1_ack_lo", 32'(ack), 32'h1);
        check("t1_busy_end", 32'(busy), 32'h1);
        stop_c();
        check("t1_busy_after_stop", 32'(busy), 32'h0);
        check("t1_rx_data", 32'(rx_data), 32'hA55A);
        check("t1_vld_pulses", 32'(vld_cnt - v0), 32'd1);
        check("t1_err_pulses", 32'(err_cnt - e0), 32'd0);

        // Foreign address 0x1B
        snap();
        start_c();
        send_byte(8'h36, ack); check("t2_ack_addr", 32'(ack), 32'h0);
        send_byte(8'h12, ack); check("t2_ack_hi", 32'(ack), 32'h0);
        send_byte(8'h34, ack); check("t2_ack_lo", 32'(ack), 32'h0);
        stop_c();
        check("t2_sda_driven", 32'(drv_cnt - d0), 32'd0);
        check("t2_vld_pulses", 32'(vld_cnt - v0), 32'd0);
        check("t2_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("t2_rx_data", 32'(rx_data), 32'hA55A);

        // Own address with read bit
        snap();
        start_c();
        send_byte(8'h35, ack); check("t3_ack_addr", 32'(ack), 32'h0);
        stop_c();
        check("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t3_vld_pulses", 32'(vld_cnt - v0), 32'd0);
        check("t3_busy", 32'(busy), 32'h0);

        // Repeated START after one data byte
        snap();
        start_c();
        send_byte(8'h34, ack); check("t4_ack_addr1", 32'(ack), 32'h1);
        send_byte(8'h12, ack); check("t4_ack_12", 32'(ack), 32'h1);
        start_c();
        send_byte(8'h34, ack); check("t4_ack_addr2", 32'(ack), 32'h1);
        send_byte(8'hBE, ack); check("t4_ack_be", 32'(ack), 32'h1);
        send_byte(8'hEF, ack); check("t4_ack_ef", 32'(ack), 32'h1);
        stop_c();
        check("t4_vld_pulses", 32'(vld_cnt - v0), 32'd1);
        check("t4_rx_data", 32'(rx_data), 32'hBEEF);
        check("t4_err_pulses", 32'(err_cnt - e0), 32'd0);

        // Three data bytes: third is refused
        snap();
        start_c();
        send_byte(8'h34, ack); check("t5_ack_addr", 32'(ack), 32'h1);
        send_byte(8'h01, ack); check("t5_ack_01", 32'(ack), 32'h1);
        send_byte(8'h02, ack); check("t5_ack_02", 32'(ack), 32'h1);
        check("t5_rx_data_word", 32'(rx_data), 32'h0102);
        check("t5_vld_after_word", 32'(vld_cnt - v0), 32'd1);
        send_byte(8'h03, ack); check("t5_ack_03", 32'(ack), 32'h0);
        stop_c();
        check("t5_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t5_vld_pulses", 32'(vld_cnt - v0), 32'd1);
        check("t5_rx_data", 32'(rx_data), 32'h0102);

        // Reset during the ACK of the high byte
        start_c();
        send_byte(8'h34, ack); check("t6_ack_addr", 32'(ack), 32'h1);
        hb = 8'h11;
        for (int i = 7; i >= 0; i--) bit_tx(hb[i], dummy);
        #Q;
        check("t6_sda_acking", 32'(sda_w), 32'h0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("t6_sda_released", 32'(sda_w), 32'h1);
        check("t6_rx_data_rst", 32'(rx_data), 32'h0000);
        check("t6_busy_rst", 32'(busy), 32'h0);
        check("t6_vld_rst", 32'(rx_vld), 32'h0);
        check("t6_err_rst", 32'(rx_err), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        snap();
        start_c();
        send_byte(8'h34, ack); check("t6_ack_addr2", 32'(ack), 32'h1);
        send_byte(8'h00, ack); check("t6_ack_00", 32'(ack), 32'h1);
        send_byte(8'hFF, ack); check("t6_ack_ff", 32'(ack), 32'h1);
        stop_c();
        check("t6_rx_data", 32'(rx_data), 32'h00FF);
        check("t6_vld_pulses", 32'(vld_cnt - v0), 32'd1);
        check("t6_err_pulses", 32'(err_cnt - e0), 32'd0);

        check("vld_err_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
